// File: rtl/kcpsmx_scratch_dma.sv
// kcpsmx_scratch_dma: block COPY/FILL/SUM engine driving the KCPSMX scratchpad port.
module kcpsmx_scratch_dma #(
    parameter int SCRATCH_DEPTH = 6,
    parameter int SCRATCH_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [SCRATCH_DEPTH-1:0] cmd_src,
    input  logic [SCRATCH_DEPTH-1:0] cmd_dst,
    input  logic [SCRATCH_DEPTH:0]   cmd_len,
    input  logic [SCRATCH_WIDTH-1:0] cmd_data,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [SCRATCH_WIDTH-1:0] result,
    output logic [SCRATCH_DEPTH-1:0] sp_address,
    output logic                     sp_write_enable,
    output logic [SCRATCH_WIDTH-1:0] sp_data_in,
    input  logic [SCRATCH_WIDTH-1:0] sp_data_out
);
    typedef enum logic [2:0] {IDLE, CP_RD, CP_WR, FILL, SUM, DONE} state_t;
    localparam logic [SCRATCH_DEPTH:0]   MAX_LEN = (SCRATCH_DEPTH+1)'(2**SCRATCH_DEPTH);
    localparam logic [SCRATCH_DEPTH:0]   ONE_LEN = (SCRATCH_DEPTH+1)'(1);
    localparam logic [SCRATCH_DEPTH-1:0] ONE_PTR = SCRATCH_DEPTH'(1);
    state_t                     r_state, w_next;
    logic [SCRATCH_DEPTH-1:0]   r_src, r_dst, r_addr;
    logic [SCRATCH_DEPTH:0]     r_rem;
    logic [SCRATCH_WIDTH-1:0]   r_data, r_hold, r_result, r_wdata;
    logic                       r_err;
    logic                       w_accept, w_bad, w_last;
    assign w_accept        = cmd_valid && r_state == IDLE;
    assign w_bad           = cmd_op == 2'b11 || cmd_len > MAX_LEN;
    assign w_last          = r_rem == ONE_LEN;
    assign cmd_ready       = r_state == IDLE;
    assign busy            = r_state != IDLE && r_state != DONE;
    assign done            = r_state == DONE;
    assign err             = done && r_err;
    assign result          = r_result;
    assign sp_write_enable = r_state == CP_WR || r_state == FILL;
    // Outside of an access the port keeps presenting whatever it drove last.
    assign sp_address      = (r_state == CP_RD || r_state == SUM) ? r_src :
                             sp_write_enable ? r_dst : r_addr;
    assign sp_data_in      = r_state == CP_WR ? r_hold : r_state == FILL ? r_data : r_wdata;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept)
                           w_next = (w_bad || cmd_len == '0) ? DONE :
                                    cmd_op == 2'b00 ? CP_RD : cmd_op == 2'b01 ? FILL : SUM;
            CP_RD:     w_next = abort ? DONE : CP_WR;
            CP_WR:     w_next = (abort || w_last) ? DONE : CP_RD;
            FILL, SUM: w_next = (abort || w_last) ? DONE : r_state;
            default:   w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_addr   <= '0;
            r_rem    <= '0;
            r_data   <= '0;
            r_hold   <= '0;
            r_result <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_addr  <= sp_address;
            r_wdata <= sp_data_in;
            if (w_accept) begin
                r_src    <= cmd_src;
                r_dst    <= cmd_dst;
                r_rem    <= cmd_len;
                r_data   <= cmd_data;
                r_result <= '0;
                r_err    <= w_bad;
            end
            if (busy && abort) r_err <= 1'b1;
            if (r_state == CP_RD) r_hold <= sp_data_out;
            if (sp_write_enable) r_dst <= r_dst + ONE_PTR;
            if (r_state == CP_WR || r_state == SUM) r_src <= r_src + ONE_PTR;
            if (r_state == CP_WR || r_state == FILL || r_state == SUM) r_rem <= r_rem - ONE_LEN;
            if (r_state == SUM) r_result <= r_result + sp_data_out;
        end
    end
endmodule

// File: tb/tb_kcpsmx_scratch_dma.sv
// tb_kcpsmx_scratch_dma: random and directed commands against an array-level reference of the scratchpad.
module tb_kcpsmx_scratch_dma;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [5:0] cmd_src = '0, cmd_dst = '0;
    logic [6:0] cmd_len = '0;
    logic [7:0] cmd_data = '0;
    logic       abort = 1'b0, busy, done, err;
    logic [7:0] result, sp_data_in, sp_data_out;
    logic [5:0] sp_address;
    logic       sp_write_enable;
    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    logic       pk_en = 1'b0;
    logic [5:0] pk_a = '0;
    logic [7:0] pk_v = '0;
    int         wr_cnt = 0;
    int         n_vec = 0, n_bad = 0;

    kcpsmx_scratch_dma dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .abort(abort), .busy(busy), .done(done), .err(err),
        .result(result), .sp_address(sp_address), .sp_write_enable(sp_write_enable),
        .sp_data_in(sp_data_in), .sp_data_out(sp_data_out)
    );

    always #5 clk = ~clk;

    // Scratchpad RAM: combinational read, write on the rising edge; pk_* is a bench-only preload port.
    assign sp_data_out = mem[sp_address];
    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_v;
        else if (sp_write_enable) mem[sp_address] <= sp_data_in;
        if (sp_write_enable) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        @(negedge clk);
        pk_en = 1'b1; pk_a = 6'(a); pk_v = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic run(input string tag, input int op, input int src, input int dst,
                       input int len, input logic [7:0] fill, input int abort_at);
        int t, k, cyc, w0, exp_cyc, exp_wr;
        logic exp_err, aborted;
        logic [7:0] exp_res;
        exp_err = (op == 3) || (len > 64);
        exp_res = 8'h00;
        exp_wr  = 0;
        exp_cyc = 1;
        if (op != 3 && len >= 1 && len <= 64) begin
            t = (op == 0) ? 2 * len : len;
            aborted = abort_at >= 1 && abort_at <= t;
            k = aborted ? abort_at : t;
            exp_err = aborted;
            exp_cyc = k + 1;
            if (op == 0) begin
                exp_wr = k / 2;
                for (int i = 0; i < k / 2; i++) ref_mem[(dst + i) % 64] = ref_mem[(src + i) % 64];
            end else if (op == 1) begin
                exp_wr = k;
                for (int i = 0; i < k; i++) ref_mem[(dst + i) % 64] = fill;
            end else begin
                for (int i = 0; i < k; i++) exp_res += ref_mem[(src + i) % 64];
            end
        end
        @(negedge clk);
        chk({tag, ".ready"}, cmd_ready, 1);
        cmd_op = 2'(op); cmd_src = 6'(src); cmd_dst = 6'(dst);
        cmd_len = 7'(len); cmd_data = fill; cmd_valid = 1'b1;
        w0 = wr_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            abort = (cyc == abort_at);
            @(posedge clk); #1;
            abort = 1'b0;
            cyc++;
        end
        chk({tag, ".cycles"}, cyc, exp_cyc);
        chk({tag, ".err"}, err, exp_err);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".writes"}, wr_cnt - w0, exp_wr);
        check_ram({tag, ".ram"});
        @(posedge clk); #1;
        chk({tag, ".idle"}, {done, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        #12;
        chk("rst.outs", {cmd_ready, busy, done, err, sp_write_enable}, 5'b10000);
        chk("rst.result", result, 0);
        chk("rst.addr", sp_address, 0);
        chk("rst.wdata", sp_data_in, 0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 64; i++) poke(i, 8'($urandom));

        run("fill", 1, 0, 10, 4, 8'hA5, 0);
        chk("fill.addr_hold", sp_address, 13);
        chk("fill.data_hold", sp_data_in, 8'hA5);

        poke(0, 8'h01); poke(1, 8'h02); poke(2, 8'h03); poke(3, 8'hFF);
        run("sum", 2, 0, 0, 4, 8'h00, 0);
        chk("sum.wrap", result, 8'h05);

        poke(62, 8'h11); poke(63, 8'h22); poke(0, 8'h33);
        run("copy_wrap", 0, 62, 20, 3, 8'h00, 0);
        chk("copy_wrap.bytes", {mem[20], mem[21], mem[22]}, 24'h112233);

        poke(5, 8'h7E);
        run("overlap", 0, 5, 6, 3, 8'h00, 0);
        chk("overlap.bytes", {mem[6], mem[7], mem[8]}, 24'h7E7E7E);

        run("bad_op", 3, 1, 2, 5, 8'h00, 0);
        run("oversize", 0, 1, 2, 65, 8'h00, 0);
        run("len0", 2, 1, 2, 0, 8'h00, 0);
        run("fill_abort", 1, 0, 0, 64, 8'h5C, 3);
        run("sum_abort_last", 2, 7, 0, 2, 8'h00, 2);

        // Asynchronous reset mid-COPY: only the first byte has been written by then.
        @(negedge clk);
        cmd_op = 2'b00; cmd_src = 6'd30; cmd_dst = 6'd40; cmd_len = 7'd8; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.outs", {cmd_ready, busy, done, err, sp_write_enable}, 5'b10000);
        chk("rst_mid.addr", sp_address, 0);
        chk("rst_mid.wdata", sp_data_in, 0);
        chk("rst_mid.result", result, 0);
        ref_mem[40] = ref_mem[30];
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        run("post_rst_sum", 2, 28, 0, 16, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            int op, len, ab;
            op  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 66) : $urandom_range(1, 12);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
            run("rand", op, $urandom_range(0, 63), $urandom_range(0, 63), len, 8'($urandom), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
